// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register names and status codes.
package y86_pkg;

  localparam int unsigned NREGS = 15;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_e;

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file: two write ports (M beats E on the same entry), two
// zero-latency read ports; address RNONE reads as zero and never writes.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_000F_FFF8,
  parameter logic [63:0] REG_INIT   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e_i,
  input  logic [3:0]  wa_e_i,
  input  logic [63:0] wd_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  wa_m_i,
  input  logic [63:0] wd_m_i,
  input  logic [3:0]  raddr_a_i,
  input  logic [3:0]  raddr_b_i,
  output logic [63:0] rdata_a_o,
  output logic [63:0] rdata_b_o
);

  logic [63:0] regs_q [NREGS];

  // Register storage with per-entry write-port arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(RSP)) ? STACK_INIT : REG_INIT;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m_i && (wa_m_i == 4'(i))) begin
          regs_q[i] <= wd_m_i;
        end else if (we_e_i && (wa_e_i == 4'(i))) begin
          regs_q[i] <= wd_e_i;
        end else begin
          regs_q[i] <= regs_q[i];
        end
      end
    end
  end

  // No bypass: a read in the write cycle returns the pre-edge contents.
  always_comb begin
    rdata_a_o = 64'h0;
    rdata_b_o = 64'h0;
    if (raddr_a_i != RNONE) begin
      rdata_a_o = regs_q[raddr_a_i];
    end else begin
      rdata_a_o = 64'h0;
    end
    if (raddr_b_i != RNONE) begin
      rdata_b_o = regs_q[raddr_b_i];
    end else begin
      rdata_b_o = 64'h0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 SEQ write-back stage: destination decode, sticky status FSM,
// retired-instruction counter and the architectural register file.
module wb_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'h0000_0000_000F_FFF8,
  parameter logic [63:0] REG_INIT   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        imem_error,
  input  logic        instr_inv,
  input  logic        dmem_error,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [63:0] rdata_a,
  output logic [63:0] rdata_b,
  output logic [2:0]  stat,
  output logic        halted,
  output logic [63:0] retired
);

  stat_e       stat_q, stat_d, next_stat_s;
  logic [63:0] retired_q, retired_d;
  logic [3:0]  dst_e_s, dst_m_s;
  logic        accept_s, commit_s;

  // Destination decode.
  always_comb begin
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    case (icode)
      I_CMOVXX: begin
        if (cnd) dst_e_s = rB;
        else     dst_e_s = RNONE;
      end
      I_IRMOVQ, I_OPQ:                 dst_e_s = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e_s = RSP;
      default:                         dst_e_s = RNONE;
    endcase
    case (icode)
      I_MRMOVQ, I_POPQ: dst_m_s = rA;
      default:          dst_m_s = RNONE;
    endcase
  end

  // Status of the current instruction; address faults outrank illegal ones.
  always_comb begin
    next_stat_s = S_AOK;
    if (imem_error || dmem_error) begin
      next_stat_s = S_ADR;
    end else if (instr_inv) begin
      next_stat_s = S_INS;
    end else if (icode == I_HALT) begin
      next_stat_s = S_HLT;
    end else begin
      next_stat_s = S_AOK;
    end
  end

  assign accept_s = instr_valid && (stat_q == S_AOK);
  assign commit_s = accept_s && (next_stat_s == S_AOK);

  // Next-state logic: non-AOK status is absorbing until reset.
  always_comb begin
    stat_d    = stat_q;
    retired_d = retired_q;
    if (accept_s) begin
      stat_d = next_stat_s;
      if ((next_stat_s == S_AOK) || (next_stat_s == S_HLT)) begin
        retired_d = retired_q + 64'd1;
      end else begin
        retired_d = retired_q;
      end
    end else begin
      stat_d    = stat_q;
      retired_d = retired_q;
    end
  end

  // Status and retired-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q    <= S_AOK;
      retired_q <= 64'd0;
    end else begin
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  y86_regfile #(
    .STACK_INIT (STACK_INIT),
    .REG_INIT   (REG_INIT)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_e_i    (commit_s && (dst_e_s != RNONE)),
    .wa_e_i    (dst_e_s),
    .wd_e_i    (valE),
    .we_m_i    (commit_s && (dst_m_s != RNONE)),
    .wa_m_i    (dst_m_s),
    .wd_m_i    (valM),
    .raddr_a_i (raddr_a),
    .raddr_b_i (raddr_b),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  assign stat    = stat_q;
  assign halted  = (stat_q != S_AOK);
  assign retired = retired_q;

endmodule
